// File: rtl/dcache_wt_if.sv
// Backing-memory request/ready bus between dcache_wt (master) and its data memory (slave).
interface dcache_wt_if #(
    parameter int XLEN      = 32,
    parameter int ADDR_BITS = 10
);
    logic                 bk_req;
    logic                 bk_we;
    logic [3:0]           bk_be;
    logic [ADDR_BITS-1:0] bk_addr;
    logic [XLEN-1:0]      bk_wdata;
    logic [XLEN-1:0]      bk_rdata;
    logic                 bk_ready;

    modport master (
        output bk_req, bk_we, bk_be, bk_addr, bk_wdata,
        input  bk_rdata, bk_ready
    );

    modport slave (
        input  bk_req, bk_we, bk_be, bk_addr, bk_wdata,
        output bk_rdata, bk_ready
    );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Define DCACHE_STATS_EN to add the stat_hits / stat_misses counters.
module dcache_wt #(
    parameter int XLEN      = 32,
    parameter int IDX_BITS  = 3,
    parameter int ADDR_BITS = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MEM_ld,
    input  logic            MEM_str,
    input  logic            MEM_byt,
    input  logic [XLEN-1:0] MEM_addr,
    input  logic [XLEN-1:0] MEM_wdata,
    output logic [XLEN-1:0] MEM_rdata,
    output logic            MEM_stall,
`ifdef DCACHE_STATS_EN
    output logic [31:0]     stat_hits,
    output logic [31:0]     stat_misses,
`endif
    dcache_wt_if.master     bk
);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS - 2;
    localparam int LINES    = 1 << IDX_BITS;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, RESP} state_t;

    state_t              state;
    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [XLEN-1:0]     data_mem [LINES];
    logic [XLEN-1:0]     resp_word;

    logic [IDX_BITS-1:0] idx;
    logic [1:0]          lane;
    logic [TAG_BITS-1:0] addr_tag;
    logic                hit;
    logic                accept;
    logic [3:0]          st_be;
    logic [XLEN-1:0]     st_wdata;
    logic                unused_addr_hi;

    assign idx            = MEM_addr[IDX_BITS+1:2];
    assign lane           = MEM_addr[1:0];
    assign addr_tag       = MEM_addr[ADDR_BITS-1:IDX_BITS+2];
    assign hit            = valid[idx] && (tag_mem[idx] == addr_tag);
    assign accept         = bk.bk_req && bk.bk_ready;
    assign st_be          = MEM_byt ? (4'b0001 << lane) : 4'hF;
    assign st_wdata       = MEM_byt ? {4{MEM_wdata[7:0]}} : MEM_wdata;
    assign unused_addr_hi = ^MEM_addr[XLEN-1:ADDR_BITS];

    function automatic logic [XLEN-1:0] load_view(input logic [XLEN-1:0] word,
                                                  input logic [1:0] ln, input logic byt);
        if (byt) return {{(XLEN-8){1'b0}}, word[{ln, 3'b000} +: 8]};
        return word;
    endfunction

    function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old_word,
                                              input logic [XLEN-1:0] new_word,
                                              input logic [3:0] be);
        logic [XLEN-1:0] r;
        r = old_word;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[i*8 +: 8] = new_word[i*8 +: 8];
        return r;
    endfunction

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        MEM_stall = 1'b0;
        MEM_rdata = '0;
        if (rst) begin
            unique case (state)
                IDLE: begin
                    if (MEM_ld) begin
                        if (hit) MEM_rdata = load_view(data_mem[idx], lane, MEM_byt);
                        else     MEM_stall = 1'b1;
                    end else if (MEM_str) begin
                        MEM_stall = 1'b1;
                    end
                end
                RD_MISS: MEM_stall = 1'b1;
                WR_THRU: MEM_stall = !bk.bk_ready;
                RESP:    MEM_rdata = load_view(resp_word, lane, MEM_byt);
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            valid       <= '0;
            resp_word   <= '0;
            bk.bk_req   <= 1'b0;
            bk.bk_we    <= 1'b0;
            bk.bk_be    <= 4'h0;
            bk.bk_addr  <= '0;
            bk.bk_wdata <= '0;
`ifdef DCACHE_STATS_EN
            stat_hits   <= '0;
            stat_misses <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (MEM_ld && !hit) begin
                        state      <= RD_MISS;
                        bk.bk_req  <= 1'b1;
                        bk.bk_we   <= 1'b0;
                        bk.bk_be   <= 4'hF;
                        bk.bk_addr <= {MEM_addr[ADDR_BITS-1:2], 2'b00};
`ifdef DCACHE_STATS_EN
                        stat_misses <= stat_misses + 32'd1;
`endif
                    end else if (MEM_str) begin
                        state       <= WR_THRU;
                        bk.bk_req   <= 1'b1;
                        bk.bk_we    <= 1'b1;
                        bk.bk_be    <= st_be;
                        bk.bk_addr  <= {MEM_addr[ADDR_BITS-1:2], 2'b00};
                        bk.bk_wdata <= st_wdata;
                    end
`ifdef DCACHE_STATS_EN
                    if (MEM_ld && hit) stat_hits <= stat_hits + 32'd1;
`endif
                end
                RD_MISS: begin
                    if (accept) begin
                        valid[idx] <= 1'b1;
                        resp_word  <= bk.bk_rdata;
                        bk.bk_req  <= 1'b0;
                        state      <= RESP;
                    end
                end
                WR_THRU: begin
                    if (accept) begin
                        bk.bk_req <= 1'b0;
                        bk.bk_we  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: line data and tags are not reset; the cleared valid bits make them don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == RD_MISS && accept) begin
                data_mem[idx] <= bk.bk_rdata;
                tag_mem[idx]  <= addr_tag;
            end else if (state == WR_THRU && accept && hit) begin
                data_mem[idx] <= merge(data_mem[idx], st_wdata, st_be);
            end
        end
    end
endmodule

// File: tb/tb_dcache_wt.sv
// Directed self-checking bench for dcache_wt with a latency-programmable backing memory.
module tb_dcache_wt;
    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_ld, MEM_str, MEM_byt;
    logic [31:0] MEM_addr, MEM_wdata, MEM_rdata;
    logic        MEM_stall;
`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    dcache_wt_if #(.XLEN(32), .ADDR_BITS(10)) bk();

    dcache_wt #(.XLEN(32), .IDX_BITS(3), .ADDR_BITS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .MEM_ld    (MEM_ld),
        .MEM_str   (MEM_str),
        .MEM_byt   (MEM_byt),
        .MEM_addr  (MEM_addr),
        .MEM_wdata (MEM_wdata),
        .MEM_rdata (MEM_rdata),
        .MEM_stall (MEM_stall),
`ifdef DCACHE_STATS_EN
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses),
`endif
        .bk        (bk)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Backing memory: bk_ready pulses in the lat-th cycle bk_req is high.
    int   lat = 3;
    bit   force_ready = 0;
    int   cnt = 0;
    logic [31:0] mem [256];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[16] = 32'hDEADBEEF;  // 0x40
        mem[17] = 32'h01020304;  // 0x44
        mem[19] = 32'h5A5A1234;  // 0x4C
        mem[24] = 32'hCAFEF00D;  // 0x60
        bk.bk_ready = 1'b0;
        bk.bk_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (force_ready) begin
                bk.bk_ready = 1'b1;
            end else if (bk.bk_req && !bk.bk_ready) begin
                cnt++;
                if (cnt >= lat) begin
                    bk.bk_ready = 1'b1;
                    bk.bk_rdata = mem[bk.bk_addr[9:2]];
                    if (bk.bk_we)
                        for (int b = 0; b < 4; b++)
                            if (bk.bk_be[b]) mem[bk.bk_addr[9:2]][b*8 +: 8] = bk.bk_wdata[b*8 +: 8];
                end
            end else begin
                bk.bk_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // Results of the last access.
    int          r_stalls;
    logic [31:0] r_rdata, r_wd;
    logic [9:0]  r_addr;
    logic [3:0]  r_be;
    bit          r_req, r_we;

    // Called at posedge+1; returns at posedge+1 after the completing cycle.
    task automatic access(input bit ld, input bit st, input bit byt,
                          input logic [31:0] addr, input logic [31:0] wd);
        bit done = 0;
        MEM_ld = ld; MEM_str = st; MEM_byt = byt; MEM_addr = addr; MEM_wdata = wd;
        r_stalls = 0; r_req = 0; r_we = 0; r_be = 0; r_wd = 0; r_addr = 0; r_rdata = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bk.bk_req) begin
                r_req = 1; r_we = bk.bk_we; r_be = bk.bk_be; r_wd = bk.bk_wdata; r_addr = bk.bk_addr;
            end
            if (!MEM_stall) begin
                r_rdata = MEM_rdata;
                done = 1;
                break;
            end
            r_stalls++;
        end
        if (!done) check("access_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        MEM_ld = 0; MEM_str = 0; MEM_byt = 0;
    endtask

    initial begin
        rst = 1'b0; MEM_ld = 0; MEM_str = 0; MEM_byt = 0; MEM_addr = 0; MEM_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bk_req",   {31'd0, bk.bk_req}, 32'd0);
        check("rst_bk_we",    {31'd0, bk.bk_we},  32'd0);
        check("rst_bk_be",    {28'd0, bk.bk_be},  32'd0);
        check("rst_bk_addr",  {22'd0, bk.bk_addr}, 32'd0);
        check("rst_bk_wdata", bk.bk_wdata, 32'd0);
        check("rst_stall",    {31'd0, MEM_stall}, 32'd0);
        check("rst_rdata",    MEM_rdata, 32'd0);
        @(posedge clk); #1; rst = 1'b1;

        // Cold load miss, latency 3
        access(1, 0, 0, 32'h40, 0);
        check("miss40_stalls", r_stalls, 32'd4);
        check("miss40_rdata",  r_rdata, 32'hDEADBEEF);
        check("miss40_req",    {31'd0, r_req}, 32'd1);
        check("miss40_we",     {31'd0, r_we}, 32'd0);
        check("miss40_addr",   {22'd0, r_addr}, 32'h40);
        check("miss40_be",     {28'd0, r_be}, 32'hF);
        access(1, 0, 0, 32'h40, 0);
        check("hit40_stalls", r_stalls, 32'd0);
        check("hit40_rdata",  r_rdata, 32'hDEADBEEF);
        check("hit40_req",    {31'd0, r_req}, 32'd0);
`ifdef DCACHE_STATS_EN
        check("stat_misses", stat_misses, 32'd1);
        check("stat_hits",   stat_hits, 32'd1);
`endif

        access(1, 0, 1, 32'h43, 0);
        check("ldb43_rdata",  r_rdata, 32'h000000DE);
        check("ldb43_stalls", r_stalls, 32'd0);
        check("ldb43_req",    {31'd0, r_req}, 32'd0);

        // Byte store hit, lane 1
        access(0, 1, 1, 32'h41, 32'h123456AA);
        check("stb41_be",     {28'd0, r_be}, 32'h2);
        check("stb41_wdata",  r_wd, 32'hAAAAAAAA);
        check("stb41_we",     {31'd0, r_we}, 32'd1);
        check("stb41_stalls", r_stalls, 32'd3);
        access(1, 0, 0, 32'h40, 0);
        check("merge40_rdata",  r_rdata, 32'hDEADAAEF);
        check("merge40_stalls", r_stalls, 32'd0);
        check("bk_mem40",       mem[16], 32'hDEADAAEF);

        // Store miss does not allocate
        access(0, 1, 0, 32'h80, 32'h11223344);
        check("st80_be", {28'd0, r_be}, 32'hF);
        access(1, 0, 0, 32'h80, 0);
        check("ld80_req",    {31'd0, r_req}, 32'd1);
        check("ld80_we",     {31'd0, r_we}, 32'd0);
        check("ld80_rdata",  r_rdata, 32'h11223344);
        check("ld80_stalls", r_stalls, 32'd4);

        // Conflict eviction on index 0
        access(1, 0, 0, 32'h40, 0);
        check("ev40_req",   {31'd0, r_req}, 32'd1);
        check("ev40_rdata", r_rdata, 32'hDEADAAEF);
        access(1, 0, 0, 32'h60, 0);
        check("ev60_req",   {31'd0, r_req}, 32'd1);
        check("ev60_rdata", r_rdata, 32'hCAFEF00D);
        access(1, 0, 0, 32'h40, 0);
        check("re40_req",   {31'd0, r_req}, 32'd1);

        // Same-cycle acceptance
        lat = 1;
        access(1, 0, 0, 32'h44, 0);
        check("l1_miss44_stalls", r_stalls, 32'd2);
        check("l1_miss44_rdata",  r_rdata, 32'h01020304);
        access(1, 0, 1, 32'h46, 0);
        check("ldb46_rdata", r_rdata, 32'h00000002);
        access(0, 1, 0, 32'h44, 32'h55667788);
        check("l1_st44_stalls", r_stalls, 32'd1);
        access(1, 0, 0, 32'h44, 0);
        check("hit44_rdata",  r_rdata, 32'h55667788);
        check("hit44_stalls", r_stalls, 32'd0);

        // Stray bk_ready with no request is ignored
        force_ready = 1;
        repeat (2) @(posedge clk);
        #1; force_ready = 0;
        @(negedge clk);
        check("stray_req",   {31'd0, bk.bk_req}, 32'd0);
        check("stray_stall", {31'd0, MEM_stall}, 32'd0);
        @(posedge clk); #1;
        access(1, 0, 0, 32'h44, 0);
        check("stray_hit44", r_rdata, 32'h55667788);
        check("stray_hit44_stalls", r_stalls, 32'd0);

        // Reset during RD_MISS abandons the fill
        lat = 10;
        MEM_ld = 1; MEM_addr = 32'h4C;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; MEM_ld = 0;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_req",   {31'd0, bk.bk_req}, 32'd0);
        check("rstmid_stall", {31'd0, MEM_stall}, 32'd0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        lat = 3;
        access(1, 0, 0, 32'h4C, 0);
        check("after_rst_req",    {31'd0, r_req}, 32'd1);
        check("after_rst_stalls", r_stalls, 32'd4);
        check("after_rst_rdata",  r_rdata, 32'h5A5A1234);
        access(1, 0, 0, 32'h44, 0);
        check("after_rst_44_req", {31'd0, r_req}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
